// File: rtl/ssp_pkg.sv
// Shared types and SSP register map for the APB command master.
package ssp_pkg;

    localparam int SSP_ADDR_W = 10;
    localparam int SSP_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // SSP register word addresses (byte address bits [11:2])
    localparam logic [SSP_ADDR_W-1:0] SSP_CR0        = 10'h000;
    localparam logic [SSP_ADDR_W-1:0] SSP_CR1        = 10'h001;
    localparam logic [SSP_ADDR_W-1:0] SSP_DR         = 10'h002;
    localparam logic [SSP_ADDR_W-1:0] SSP_SR         = 10'h003;
    localparam logic [SSP_ADDR_W-1:0] SSP_CPSR       = 10'h004;
    localparam logic [SSP_ADDR_W-1:0] SSP_IMSC       = 10'h005;
    localparam logic [SSP_ADDR_W-1:0] SSP_RIS        = 10'h006;
    localparam logic [SSP_ADDR_W-1:0] SSP_MIS        = 10'h007;
    localparam logic [SSP_ADDR_W-1:0] SSP_ICR        = 10'h008;
    localparam logic [SSP_ADDR_W-1:0] SSP_DMACR      = 10'h009;
    localparam logic [SSP_ADDR_W-1:0] SSP_PERIPHID0  = 10'h3F8;
    localparam logic [SSP_ADDR_W-1:0] SSP_PERIPHID1  = 10'h3F9;
    localparam logic [SSP_ADDR_W-1:0] SSP_PERIPHID2  = 10'h3FA;
    localparam logic [SSP_ADDR_W-1:0] SSP_PERIPHID3  = 10'h3FB;
    localparam logic [SSP_ADDR_W-1:0] SSP_PCELLID0   = 10'h3FC;
    localparam logic [SSP_ADDR_W-1:0] SSP_PCELLID1   = 10'h3FD;
    localparam logic [SSP_ADDR_W-1:0] SSP_PCELLID2   = 10'h3FE;
    localparam logic [SSP_ADDR_W-1:0] SSP_PCELLID3   = 10'h3FF;

    typedef struct packed {
        logic                  write;
        logic [SSP_ADDR_W-1:0] addr;
        logic [SSP_DATA_W-1:0] wdata;
    } cmd_t;

    // True for any word address the SSP actually decodes.
    function automatic logic is_ssp_reg(input logic [SSP_ADDR_W-1:0] a);
        return a inside {SSP_CR0, SSP_CR1, SSP_DR, SSP_SR, SSP_CPSR, SSP_IMSC,
                         SSP_RIS, SSP_MIS, SSP_ICR, SSP_DMACR,
                         SSP_PERIPHID0, SSP_PERIPHID1, SSP_PERIPHID2, SSP_PERIPHID3,
                         SSP_PCELLID0, SSP_PCELLID1, SSP_PCELLID2, SSP_PCELLID3};
    endfunction

endpackage

// File: rtl/ssp_apb_cmd_master_if.sv
// Command/response stream plus APB register port of the SSP command master.
interface ssp_apb_cmd_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // View of the command master itself
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // View of the agents around it (command source, response sink, APB slave)
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/ssp_apb_cmd_master.sv
// Single-outstanding APB master: one valid/ready command in, one APB transfer,
// one response out.
//
// state  | meaning
// IDLE   | ready for a command, APB idle
// SETUP  | APB setup phase (PSEL=1, PENABLE=0), always one cycle
// ACCESS | APB access phase, waiting for PREADY or timeout
// RESP   | response presented, held until rsp_ready
module ssp_apb_cmd_master
    import ssp_pkg::*;
#(
    parameter int ADDR_W  = SSP_ADDR_W,
    parameter int DATA_W  = SSP_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    ssp_apb_cmd_master_if.master bus,
    output logic [15:0]          txn_count
);

    // Last ACCESS cycle allowed without PREADY before the transfer is abandoned.
    localparam logic [15:0] WAIT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [15:0]       wait_q, wait_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [15:0]       txn_q, txn_d;

    // Upper PRDATA bits are not part of the 16-bit SSP register space.
    logic unused_prdata;
    assign unused_prdata = ^bus.PRDATA[31:DATA_W];

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign txn_count     = txn_q;

    // State and datapath registers; reset kills any in-flight transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    // Next-state, APB drive and response capture.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        wait_d        = wait_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        txn_d         = txn_q;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        bus.PWRITE    = 1'b0;
        bus.PADDR     = '0;
        bus.PWDATA    = '0;

        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    cmd_d.write = bus.cmd_write;
                    cmd_d.addr  = SSP_ADDR_W'(bus.cmd_addr);
                    cmd_d.wdata = SSP_DATA_W'(bus.cmd_wdata);
                    wait_d      = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                bus.PSEL   = 1'b1;
                bus.PWRITE = cmd_q.write;
                bus.PADDR  = ADDR_W'(cmd_q.addr);
                bus.PWDATA = 32'(cmd_q.wdata);
                state_d    = ACCESS;
            end
            ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
                bus.PWRITE  = cmd_q.write;
                bus.PADDR   = ADDR_W'(cmd_q.addr);
                bus.PWDATA  = 32'(cmd_q.wdata);
                if (bus.PREADY) begin
                    err_d   = bus.PSLVERR;
                    rdata_d = (!cmd_q.write && !bus.PSLVERR) ? bus.PRDATA[DATA_W-1:0] : '0;
                    txn_d   = txn_q + 16'd1;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    txn_d   = txn_q + 16'd1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ssp_apb_cmd_master.sv
// Directed bench: SSP register-port slave model around the command master.
module tb_ssp_apb_cmd_master;
    import ssp_pkg::*;

    logic        PCLK;
    logic        PRESETn;
    logic [15:0] txn_count;

    int vectors     = 0;
    int miscompares = 0;

    ssp_apb_cmd_master_if #(.ADDR_W(10), .DATA_W(16)) bus ();

    ssp_apb_cmd_master #(.ADDR_W(10), .DATA_W(16), .TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .bus       (bus),
        .txn_count (txn_count)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- SSP slave model ----------------
    int          wait_cfg   = 0;    // PREADY low cycles per access; -1 = never ready
    bit          slverr_cfg = 1'b0;
    int          acc_cnt;
    logic [15:0] cr0_r;
    logic [7:0]  id_tab [8];

    initial begin
        id_tab[0] = 8'h22; id_tab[1] = 8'h10; id_tab[2] = 8'h34; id_tab[3] = 8'h00;
        id_tab[4] = 8'h0D; id_tab[5] = 8'hF0; id_tab[6] = 8'h05; id_tab[7] = 8'hB1;
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            acc_cnt <= 0;
            cr0_r   <= 16'h0;
        end else begin
            if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
            else                                        acc_cnt <= 0;
            if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && bus.PADDR == SSP_CR0)
                cr0_r <= bus.PWDATA[15:0];
        end
    end

    always_comb begin
        bus.PREADY  = (wait_cfg >= 0) && (acc_cnt >= wait_cfg);
        bus.PSLVERR = bus.PSEL && bus.PENABLE && (slverr_cfg || !is_ssp_reg(bus.PADDR));
        bus.PRDATA  = 32'h0;
        if (bus.PSEL) begin
            if (bus.PADDR == SSP_CR0)             bus.PRDATA = {16'hA5A5, cr0_r};
            else if (bus.PADDR == SSP_SR)         bus.PRDATA = {16'hA5A5, 16'h0003};
            else if (bus.PADDR >= SSP_PERIPHID0)  bus.PRDATA = {16'hA5A5, 8'h00, id_tab[bus.PADDR[2:0]]};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] r_data;
    logic        r_err;
    int          r_lat;
    logic [2:0]  smp_setup, smp_access;   // {PSEL, PENABLE, PWRITE}
    logic [9:0]  smp_paddr;
    logic [31:0] smp_pwdata;
    logic        smp_psel_rsp;

    // One command; lat = edges after the accept edge until rsp_valid.
    // hold > 0 keeps rsp_ready low that many cycles while offering another command.
    task automatic run_cmd(input bit w, input logic [9:0] a, input logic [15:0] d, input int hold);
        int n;
        logic [15:0] held;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        smp_setup  = {bus.PSEL, bus.PENABLE, bus.PWRITE};
        smp_paddr  = bus.PADDR;
        smp_pwdata = bus.PWDATA;
        smp_access = 3'b000;
        r_lat = 0;
        while (!bus.rsp_valid && r_lat < 40) begin
            @(negedge PCLK);
            r_lat++;
            if (r_lat == 1) smp_access = {bus.PSEL, bus.PENABLE, bus.PWRITE};
        end
        r_data       = bus.rsp_rdata;
        r_err        = bus.rsp_err;
        smp_psel_rsp = bus.PSEL;
        held         = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b0;
            bus.cmd_addr  = SSP_CR1;
            @(negedge PCLK);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("hold_rdata",     32'(bus.rsp_rdata), 32'(held));
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        check("rsp_consumed", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge PCLK);
        check("rst_psel",      32'(bus.PSEL),      32'd0);
        check("rst_penable",   32'(bus.PENABLE),   32'd0);
        check("rst_paddr",     32'(bus.PADDR),     32'd0);
        check("rst_pwdata",    bus.PWDATA,         32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_txn",       32'(txn_count),     32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_rsp_ready_ignored", 32'(bus.rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.rsp_ready = 1'b0;

        // Read SSPSR, zero wait
        run_cmd(1'b0, SSP_SR, 16'h0, 0);
        check("sr_rdata",  32'(r_data),     32'h0003);
        check("sr_err",    32'(r_err),      32'd0);
        check("sr_lat",    32'(r_lat),      32'd2);
        check("sr_setup",  32'(smp_setup),  32'b100);
        check("sr_access", 32'(smp_access), 32'b110);
        check("sr_paddr",  32'(smp_paddr),  32'h003);
        check("sr_txn",    32'(txn_count),  32'd1);

        // Write CR0 then read it back
        run_cmd(1'b1, SSP_CR0, 16'h00C7, 0);
        check("wr_rdata",  32'(r_data),     32'h0);
        check("wr_err",    32'(r_err),      32'd0);
        check("wr_setup",  32'(smp_setup),  32'b101);
        check("wr_access", 32'(smp_access), 32'b111);
        check("wr_pwdata", smp_pwdata,      32'h0000_00C7);
        run_cmd(1'b0, SSP_CR0, 16'h0, 0);
        check("rd_cr0",    32'(r_data),     32'h00C7);
        check("rd_txn",    32'(txn_count),  32'd3);

        // ID words
        run_cmd(1'b0, SSP_PERIPHID0, 16'h0, 0); check("id0", 32'(r_data), 32'h22);
        run_cmd(1'b0, SSP_PERIPHID1, 16'h0, 0); check("id1", 32'(r_data), 32'h10);
        run_cmd(1'b0, SSP_PERIPHID2, 16'h0, 0); check("id2", 32'(r_data), 32'h34);
        run_cmd(1'b0, SSP_PERIPHID3, 16'h0, 0); check("id3", 32'(r_data), 32'h00);
        run_cmd(1'b0, SSP_PCELLID0,  16'h0, 0); check("id4", 32'(r_data), 32'h0D);
        run_cmd(1'b0, SSP_PCELLID1,  16'h0, 0); check("id5", 32'(r_data), 32'hF0);
        run_cmd(1'b0, SSP_PCELLID2,  16'h0, 0); check("id6", 32'(r_data), 32'h05);
        run_cmd(1'b0, SSP_PCELLID3,  16'h0, 0); check("id7", 32'(r_data), 32'hB1);
        check("id_txn", 32'(txn_count), 32'd11);

        // Three PREADY wait cycles
        wait_cfg = 3;
        run_cmd(1'b0, SSP_SR, 16'h0, 0);
        check("wait3_lat",   32'(r_lat),  32'd5);
        check("wait3_err",   32'(r_err),  32'd0);
        check("wait3_rdata", 32'(r_data), 32'h0003);

        // Slave never ready: timeout after 16 ACCESS cycles
        wait_cfg = -1;
        run_cmd(1'b0, SSP_CR0, 16'h0, 0);
        check("to_lat",   32'(r_lat),        32'd17);
        check("to_err",   32'(r_err),        32'd1);
        check("to_rdata", 32'(r_data),       32'h0);
        check("to_psel",  32'(smp_psel_rsp), 32'd0);
        check("to_txn",   32'(txn_count),    32'd13);

        // Back-pressured response with a command waiting
        wait_cfg = 0;
        run_cmd(1'b0, SSP_SR, 16'h0, 5);
        check("bp_rdata", 32'(r_data),    32'h0003);
        check("bp_txn",   32'(txn_count), 32'd14);

        // Slave error on a read
        slverr_cfg = 1'b1;
        run_cmd(1'b0, SSP_CR0, 16'h0, 0);
        slverr_cfg = 1'b0;
        check("slverr_err",   32'(r_err),     32'd1);
        check("slverr_rdata", 32'(r_data),    32'h0);
        check("slverr_txn",   32'(txn_count), 32'd15);

        // Reset during ACCESS
        wait_cfg = -1;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = SSP_CR0;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        check("pre_rst_access", 32'({bus.PSEL, bus.PENABLE}), 32'b11);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_mid_psel",    32'(bus.PSEL),    32'd0);
        check("rst_mid_penable", 32'(bus.PENABLE), 32'd0);
        wait_cfg = 0;
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        check("rst_mid_txn", 32'(txn_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
